hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Producer of the pipeline `Stall` request that the stall controller consumes. The stall controller turns `Stall` into PC_En/D_En low and an E-stage bubble.
- Tracks destination registers in flight in the E and M stages with Tnew/Tuse timing, plus a multi-cycle MULT/DIV busy counter.
- Sits beside the D stage. It raises `Stall` whenever forwarding cannot resolve a D-stage operand, or a HI/LO instruction meets a busy MDU.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E
- DIV_CYC, 10, busy cycles after a div/divu enters E
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- D_valid  in  1  D stage holds a real instruction
- D_rs  in  5  rs operand address of D instruction
- D_rt  in  5  rt operand address of D instruction
- D_Tuse_rs  in  2  cycles until rs needed: 0 = branch/jr, 1 = ALU, 3 = unused
- D_Tuse_rt  in  2  same for rt (2 = store data)
- D_wa  in  5  destination register of D instruction, 0 if none
- D_Tnew  in  2  cycles from E until result ready: 0 = none, 1 = ALU/mf, 2 = load
- D_md_start  in  1  D instruction is mult/multu/div/divu
- D_md_div  in  1  qualifies D_md_start: 1 = div, 0 = mult
- D_hilo  in  1  D instruction uses HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- Stall  out  1  stall request to stall controller
- md_busy  out  1  MDU busy counter nonzero
- stall_cnt  out  CNT_W  number of stalled cycles since reset

Behaviour:
- Shadow E/M records:
  - E record = {E_wa 5b, E_Tnew 2b}. M record = {M_wa, M_Tnew}.
  - Reset: all four fields cleared to 0.
- Each rising edge, with reset_n high:
  - M record <= {E_wa, E_Tnew saturating-decrement (0 stays 0)}.
  - If Stall = 1 or D_valid = 0: E record <= {0,0}, i.e. a bubble that mirrors E_reset.
  - Otherwise: E record <= {D_wa, D_Tnew}.
- Operand hazard on rs (rt identical with D_rt/D_Tuse_rt), all of the following true:
  - D_valid = 1, D_rs != 0, D_Tuse_rs != 3.
  - Either (E_wa == D_rs and E_Tnew > D_Tuse_rs) or (M_wa == D_rs and M_Tnew > D_Tuse_rs).
  - E-stage matches take priority only for forwarding. For stall purposes the two conditions are simply ORed.
- MDU counter (4b):
  - Reset value 0.
  - On an edge where D_valid & D_md_start & !Stall: load DIV_CYC if D_md_div, else MULT_CYC.
  - Otherwise, if nonzero, decrement by 1.
  - md_busy = (counter != 0).
  - A new start cannot arrive while busy, because it is itself a D_hilo instruction and is stalled.
- HI/LO hazard: D_valid & D_hilo & md_busy.
- Stall output:
  - Stall = rs_hazard | rt_hazard | hilo_hazard. Purely combinational from current inputs and registered state, zero latency.
  - Stall = 0 whenever D_valid = 0.
- stall_cnt:
  - Reset value 0.
  - Increments by 1 on every edge where Stall = 1.
  - Saturates at all-ones; no wrap.
- Reset output values: Stall = 0 (given D_valid = 0), md_busy = 0, stall_cnt = 0.
- Reset mid-operation: asserting reset_n low clears all records and the counter immediately, without waiting for clk. An in-progress MDU busy window is abandoned.
- Register 0 writes (D_wa = 0) never cause a hazard.

Test Plan:
- Load-use: lw $8 (D_wa=8, D_Tnew=2) issues, next D is add with rs=8 (D_Tuse_rs=1).
  -> Stall=1 for exactly 1 cycle, then 0; stall_cnt=1.
- Branch after ALU: addu $9 (D_Tnew=1), then beq rs=9 (Tuse=0).
  -> 1 stall cycle.
  - Same with a nop in between -> no stall.
- Branch after load: lw $10, then beq rt=10 (Tuse=0).
  -> Stall=1 for 2 consecutive cycles; E record bubbles on both.
- Store data after load: lw $11, then sw with rt=11 (Tuse_rt=2), rs=0.
  -> no stall.
- MDU: div issues (D_md_div=1), then mflo next cycle.
  -> md_busy=1 for 10 cycles, Stall=1 for 10 cycles, mflo proceeds on the 11th.
  - Repeat with mult -> 5 cycles.
- Zero register and reset: lw $0, then add rs=0 -> no stall.
  - Assert reset_n=0 asynchronously during a div busy window -> md_busy and stall_cnt drop to 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Purpose: D-stage hazard detector; raises Stall when forwarding cannot cover an operand or HI/LO meets a busy MDU.
// Latency: Stall is combinational (zero cycles) from D inputs and registered E/M/MDU state.
// Backpressure: Stall holds D/PC; this unit injects its own E bubble on stalled or empty-D cycles.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   D_valid                 D stage holds a real instruction
//   D_rs/D_rt, D_Tuse_*     source addresses and cycles until needed (3 = unused)
//   D_wa, D_Tnew            destination and cycles from E until result ready (0 = none)
//   D_md_start, D_md_div    D instruction starts the MDU; 1 = div, 0 = mult
//   D_hilo                  D instruction touches HI/LO
//   Stall                   stall request to the stall controller
//   md_busy                 MDU busy window active
//   stall_cnt               saturating count of stalled cycles since reset
module hazard_stall_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             D_valid,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_Tuse_rs,
    input  logic [1:0]       D_Tuse_rt,
    input  logic [4:0]       D_wa,
    input  logic [1:0]       D_Tnew,
    input  logic             D_md_start,
    input  logic             D_md_div,
    input  logic             D_hilo,
    output logic             Stall,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Shadow copies of the destination/timing of instructions in E and M.
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic [3:0] md_cnt;

    logic rs_hazard;
    logic rt_hazard;
    logic hilo_hazard;

    // A match in E or M only stalls when the producer's result is still
    // further away than the consumer's need; E-over-M priority matters for
    // forwarding only, so the two matches are simply ORed here.
    always_comb begin
        rs_hazard = 1'b0;
        rt_hazard = 1'b0;
        if (D_valid && (D_rs != 5'd0) && (D_Tuse_rs != 2'd3)) begin
            rs_hazard = ((e_wa == D_rs) && (e_tnew > D_Tuse_rs)) ||
                        ((m_wa == D_rs) && (m_tnew > D_Tuse_rs));
        end
        if (D_valid && (D_rt != 5'd0) && (D_Tuse_rt != 2'd3)) begin
            rt_hazard = ((e_wa == D_rt) && (e_tnew > D_Tuse_rt)) ||
                        ((m_wa == D_rt) && (m_tnew > D_Tuse_rt));
        end
    end

    assign md_busy     = (md_cnt != 4'd0);
    assign hilo_hazard = D_valid && D_hilo && md_busy;
    assign Stall       = rs_hazard || rt_hazard || hilo_hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_wa   <= 5'd0;
            e_tnew <= 2'd0;
            m_wa   <= 5'd0;
            m_tnew <= 2'd0;
        end else begin
            m_wa   <= e_wa;
            m_tnew <= (e_tnew != 2'd0) ? (e_tnew - 2'd1) : 2'd0;
            // Stalled or empty D advances a bubble into E.
            if (Stall || !D_valid) begin
                e_wa   <= 5'd0;
                e_tnew <= 2'd0;
            end else begin
                e_wa   <= D_wa;
                e_tnew <= D_Tnew;
            end
        end
    end

    // MDU busy window. A second start cannot collide with a live window:
    // starts are HI/LO instructions and are held by hilo_hazard while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= 4'd0;
        end else if (D_valid && D_md_start && !Stall) begin
            md_cnt <= D_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (Stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
